fp_mantissa_add_norm: RTL and testbench

// - Downstream of the fraction alignment stage: takes the aligned 24-bit significands
//   (nonShifted_val, Shifted_val) plus exponent_temp, and adds or subtracts them by sign.
// - Normalizes the result iteratively, one bit per cycle.
// - Emits a packed sign / biased exponent / 23-bit fraction via valid/ready handshake;

---
 rtl/fp_mantissa_add_norm.sv | 215 +++++++++++++++++++++
 tb/tb_fp_mantissa_add_norm.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fp_mantissa_add_norm.sv
// fp_mantissa_add_norm: adds/subtracts aligned significands by sign, normalizes
// one bit per cycle, and hands a sign/exponent/fraction result downstream over
// valid/ready. Optional status outputs are enabled with `define STATUS_FLAGS_EN.
module fp_mantissa_add_norm #(
  parameter int unsigned FRAC_W = 23,
  parameter int unsigned EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FRAC_W:0]   nonShifted_val,
  input  logic [FRAC_W:0]   Shifted_val,
  input  logic [EXP_W-1:0]  exponent_temp,
  input  logic              sign_ns,
  input  logic              sign_s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              result_sign,
  output logic [EXP_W-1:0]  result_exp,
  output logic [FRAC_W-1:0] result_frac,
`ifdef STATUS_FLAGS_EN
  output logic              flag_overflow,
  output logic              flag_zero,
  output logic              flag_denorm,
`endif
  output logic              busy
);

  localparam int unsigned SIG_W = FRAC_W + 1;
  localparam int unsigned ACC_W = FRAC_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [ACC_W-1:0] ACC_ONE  = ACC_W'(1) << FRAC_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t r_state, w_next_state;

  logic [SIG_W-1:0]  r_ns, r_s;
  logic [EXP_W-1:0]  r_exp;
  logic              r_sign_ns, r_sign_s, r_eff_sub;
  logic [ACC_W-1:0]  r_acc;
  logic              r_sign;
  logic              r_ovf, r_zero, r_denorm;

  logic              r_in_ready, r_out_valid, r_busy;
  logic              r_res_sign;
  logic [EXP_W-1:0]  r_res_exp;
  logic [FRAC_W-1:0] r_res_frac;
  logic              r_res_ovf, r_res_zero, r_res_denorm;

  logic              w_accept;
  logic              w_s_gt;
  logic [ACC_W-1:0]  w_sum, w_diff_sn, w_diff_ns;
  logic [EXP_W-1:0]  w_exp_inc;

  assign w_accept  = (r_state == IDLE) && in_valid && r_in_ready;
  assign w_s_gt    = (r_s > r_ns);
  assign w_sum     = ACC_W'(r_ns) + ACC_W'(r_s);
  assign w_diff_sn = ACC_W'(r_s) - ACC_W'(r_ns);
  assign w_diff_ns = ACC_W'(r_ns) - ACC_W'(r_s);
  assign w_exp_inc = r_exp + EXP_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next_state = ADD;
      ADD:  w_next_state = NORM;
      NORM: begin
        if ((r_acc == '0) || r_acc[FRAC_W+1] || r_acc[FRAC_W] || (r_exp <= EXP_W'(1)))
          w_next_state = DONE;
      end
      DONE: if (r_out_valid && out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake and status registers track the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_in_ready <= (w_next_state == IDLE);
      r_busy     <= (w_next_state != IDLE);
    end
  end

  // Operand capture, add/subtract and one-step-per-cycle normalization
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ns      <= '0;
      r_s       <= '0;
      r_exp     <= '0;
      r_sign_ns <= 1'b0;
      r_sign_s  <= 1'b0;
      r_eff_sub <= 1'b0;
      r_acc     <= '0;
      r_sign    <= 1'b0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
      r_denorm  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ns      <= nonShifted_val;
            r_s       <= Shifted_val;
            r_exp     <= exponent_temp;
            r_sign_ns <= sign_ns;
            r_sign_s  <= sign_s;
            r_eff_sub <= sign_ns ^ sign_s;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
            r_denorm  <= 1'b0;
          end
        end
        ADD: begin
          if (!r_eff_sub) begin
            r_acc  <= w_sum;
            r_sign <= r_sign_ns;
          end else if (w_s_gt) begin
            r_acc  <= w_diff_sn;
            r_sign <= r_sign_s;
          end else begin
            r_acc  <= w_diff_ns;
            r_sign <= r_sign_ns;
          end
          // All-ones input exponent: a normalized 1.0 acc makes NORM exit at once
          if (r_exp == EXP_ONES) begin
            r_acc <= ACC_ONE;
            r_ovf <= 1'b1;
          end
        end
        NORM: begin
          if (r_acc == '0) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
            r_zero <= 1'b1;
          end else if (r_acc[FRAC_W+1]) begin
            r_acc <= r_acc >> 1;
            r_exp <= w_exp_inc;
            if (w_exp_inc == EXP_ONES) r_ovf <= 1'b1;
          end else if (r_acc[FRAC_W]) begin
            r_acc <= r_acc;
          end else if (r_exp <= EXP_W'(1)) begin
            r_exp    <= '0;
            r_denorm <= 1'b1;
          end else begin
            r_acc <= r_acc << 1;
            r_exp <= r_exp - EXP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded on the first DONE cycle, held until handoff
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_res_sign   <= 1'b0;
      r_res_exp    <= '0;
      r_res_frac   <= '0;
      r_res_ovf    <= 1'b0;
      r_res_zero   <= 1'b0;
      r_res_denorm <= 1'b0;
    end else if (r_state == DONE) begin
      if (!r_out_valid) begin
        r_out_valid  <= 1'b1;
        r_res_sign   <= r_sign;
        r_res_exp    <= r_exp;
        r_res_frac   <= r_ovf ? '0 : r_acc[FRAC_W-1:0];
        r_res_ovf    <= r_ovf;
        r_res_zero   <= r_zero;
        r_res_denorm <= r_denorm;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready    = r_in_ready;
  assign busy        = r_busy;
  assign out_valid   = r_out_valid;
  assign result_sign = r_res_sign;
  assign result_exp  = r_res_exp;
  assign result_frac = r_res_frac;

`ifdef STATUS_FLAGS_EN
  assign flag_overflow = r_res_ovf;
  assign flag_zero     = r_res_zero;
  assign flag_denorm   = r_res_denorm;
`else
  // Flag state exists but has no port without the status option
  logic w_flags_unused;
  assign w_flags_unused = r_res_ovf ^ r_res_zero ^ r_res_denorm;
`endif

endmodule

// File: tb/tb_fp_mantissa_add_norm.sv
// Self-checking bench for fp_mantissa_add_norm: directed vector table plus
// handshake-stall and mid-operation reset sequences.
module tb_fp_mantissa_add_norm;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [23:0] nonShifted_val, Shifted_val;
  logic [7:0]  exponent_temp;
  logic        sign_ns, sign_s;
  logic        out_valid, out_ready;
  logic        result_sign;
  logic [7:0]  result_exp;
  logic [22:0] result_frac;
  logic        busy;
`ifdef STATUS_FLAGS_EN
  logic        flag_overflow, flag_zero, flag_denorm;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_mantissa_add_norm dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .nonShifted_val (nonShifted_val),
    .Shifted_val    (Shifted_val),
    .exponent_temp  (exponent_temp),
    .sign_ns        (sign_ns),
    .sign_s         (sign_s),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result_sign    (result_sign),
    .result_exp     (result_exp),
    .result_frac    (result_frac),
`ifdef STATUS_FLAGS_EN
    .flag_overflow  (flag_overflow),
    .flag_zero      (flag_zero),
    .flag_denorm    (flag_denorm),
`endif
    .busy           (busy)
  );

  typedef struct {
    string       name;
    logic [23:0] ns;
    logic [23:0] s;
    logic [7:0]  exp;
    logic        sns;
    logic        ss;
    logic        e_sign;
    logic [7:0]  e_exp;
    logic [22:0] e_frac;
    int          e_lat;
    logic        e_ovf;
    logic        e_zero;
    logic        e_den;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_result(input vec_t v);
    chk({v.name, " sign"}, 32'(result_sign), 32'(v.e_sign));
    chk({v.name, " exp"},  32'(result_exp),  32'(v.e_exp));
    chk({v.name, " frac"}, 32'(result_frac), 32'(v.e_frac));
`ifdef STATUS_FLAGS_EN
    chk({v.name, " flag_overflow"}, 32'(flag_overflow), 32'(v.e_ovf));
    chk({v.name, " flag_zero"},     32'(flag_zero),     32'(v.e_zero));
    chk({v.name, " flag_denorm"},   32'(flag_denorm),   32'(v.e_den));
`endif
  endtask

  // Wait for in_ready, present one operand set for exactly one accept edge
  task automatic send(input vec_t v);
    int cyc = 0;
    while (!in_ready && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    chk({v.name, " in_ready before send"}, 32'(in_ready), 32'd1);
    nonShifted_val = v.ns;
    Shifted_val    = v.s;
    exponent_temp  = v.exp;
    sign_ns        = v.sns;
    sign_s         = v.ss;
    in_valid       = 1'b1;
    @(posedge clk); #1;
    in_valid       = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid, bounded
  task automatic wait_valid(input vec_t v);
    int cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    chk({v.name, " latency"}, 32'(cyc), 32'(v.e_lat));
  endtask

  task automatic handoff(input vec_t v);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({v.name, " out_valid after handoff"}, 32'(out_valid), 32'd0);
    chk({v.name, " busy after handoff"},      32'(busy),      32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    send(v);
    wait_valid(v);
    check_result(v);
    handoff(v);
  endtask

  vec_t vecs[11];
  vec_t v_one, v_long;

  initial begin
    //          name           ns         s          exp     sns   ss    sign  exp     frac         lat ovf   zero  den
    vecs[0]  = '{"1.0+1.0",    24'h800000, 24'h800000, 8'd127, 1'b0, 1'b0, 1'b0, 8'd128, 23'h000000, 3, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"1.5-1.0",    24'hC00000, 24'h800000, 8'd127, 1'b0, 1'b1, 1'b0, 8'd126, 23'h000000, 4, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"swap",       24'h800000, 24'hC00000, 8'd127, 1'b0, 1'b1, 1'b1, 8'd126, 23'h000000, 4, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"cancel",     24'h800000, 24'h800000, 8'd127, 1'b0, 1'b1, 1'b0, 8'd0,   23'h000000, 3, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{"denorm e2",  24'h800000, 24'h7FFFFF, 8'd2,   1'b0, 1'b1, 1'b0, 8'd0,   23'h000002, 4, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{"overflow",   24'hFFFFFF, 24'hFFFFFF, 8'd254, 1'b0, 1'b0, 1'b0, 8'd255, 23'h000000, 3, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{"exp inf in", 24'h800000, 24'h800000, 8'd255, 1'b0, 1'b0, 1'b0, 8'd255, 23'h000000, 3, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{"1.0+0.5",    24'h800000, 24'h400000, 8'd127, 1'b0, 1'b0, 1'b0, 8'd127, 23'h400000, 3, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{"neg add",    24'h800000, 24'h800000, 8'd127, 1'b1, 1'b1, 1'b1, 8'd128, 23'h000000, 3, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{"3 shifts",   24'h800000, 24'h700000, 8'd127, 1'b0, 1'b1, 1'b0, 8'd124, 23'h000000, 6, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{"23 shifts",  24'h800000, 24'h7FFFFF, 8'd100, 1'b0, 1'b1, 1'b0, 8'd77,  23'h000000, 26, 1'b0, 1'b0, 1'b0};
    v_one    = vecs[0];
    v_long   = '{"denorm e5",  24'h800000, 24'h7FFFFF, 8'd5,   1'b0, 1'b1, 1'b0, 8'd0,   23'h000010, 7, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    nonShifted_val = '0; Shifted_val = '0; exponent_temp = '0; sign_ns = 1'b0; sign_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready",  32'(in_ready),    32'd0);
    chk("reset out_valid", 32'(out_valid),   32'd0);
    chk("reset busy",      32'(busy),        32'd0);
    chk("reset exp",       32'(result_exp),  32'd0);
    chk("reset frac",      32'(result_frac), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready after release", 32'(in_ready), 32'd1);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);
    run_vec(v_long);

    // Stall in DONE: outputs must hold and no new input may be taken
    send(v_one);
    wait_valid(v_one);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall in_ready",  32'(in_ready),  32'd0);
      check_result(v_one);
    end
    in_valid = 1'b0;
    handoff(v_one);

    // Reset in the middle of a long normalization
    send(vecs[10]);
    repeat (4) @(posedge clk);
    #1;
    chk("mid-op busy before rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid-op rst out_valid", 32'(out_valid), 32'd0);
    chk("mid-op rst busy",      32'(busy),      32'd0);
    chk("mid-op rst in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid-op in_ready after release", 32'(in_ready),  32'd1);
    chk("mid-op no stale result",        32'(out_valid), 32'd0);
    run_vec(v_one);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
